display_scan_ctrl: RTL and testbench
====================================

Name: display_scan_ctrl

Overview:
Parametrised successor to the static per-digit 7-segment controller. It holds a NUM_DIGITS-entry digit register file written through a checked write port with per-digit value, decimal point and blank flags. It drives one shared segment bus, time-multiplexed across digit enables, with a refresh prescaler, an inter-digit ghosting blank and PWM brightness control. It sits between the system datapath and the board's multiplexed 7-segment array.

Parameters:
NUM_DIGITS, 8, number of digits scanned (2..16); POS_W = max(1, clog2(NUM_DIGITS)).
REFRESH_DIV, 50000, clock cycles per digit slot (>= 4).
HEX_MODE, 0, 1 = accept and decode values 10..15 as A..F; 0 = decimal only.
PWM_BITS, 4, width of the brightness control.
ACTIVE_LOW, 1, 1 = segment and digit-enable outputs are active-low.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
wr_en  in  1  write strobe, single cycle
wr_pos  in  POS_W  target digit index
wr_data  in  4  digit value
wr_dp  in  1  decimal point for the target digit
wr_blank  in  1  1 = target digit dark
clear  in  1  synchronous blank of all digits
brightness  in  PWM_BITS  duty control
wr_ack  out  1  one-cycle pulse, write accepted
wr_err  out  1  one-cycle pulse, write rejected
an  out  NUM_DIGITS  digit enables, one-hot when active
seg  out  7  segments {g,f,e,d,c,b,a}
dp  out  1  decimal point segment
scan_idx  out  POS_W  digit currently being scanned

Behaviour:
- Reset (async assert, sync release). All entries become value=0, dp=0, blank=1. scan_idx=0, prescaler=0, pwm_cnt=0, wr_ack=wr_err=0. an, seg and dp are inactive (all 1 when ACTIVE_LOW, else all 0).
- Write acceptance: accepted when wr_en=1, wr_pos<NUM_DIGITS, and either wr_data<10 or HEX_MODE=1. On accept, the entry is updated at the clock edge and wr_ack is high for exactly the next cycle.
- Write rejection: any other wr_en=1 leaves storage unchanged, and wr_err is high for exactly the next cycle.
- clear=1: all entries get blank=1 (value and dp retained). Clear takes priority over a same-cycle write: the write is dropped, and both wr_ack and wr_err stay 0.
- Prescaler: counts 0..REFRESH_DIV-1. On the REFRESH_DIV-1 cycle it wraps to 0 and scan_idx advances. From NUM_DIGITS-1, scan_idx wraps to 0.
- Ghost blank: while prescaler==0 (first cycle of each slot), an is all inactive.
- PWM: pwm_cnt is a free-running PWM_BITS counter. Digit enabled when brightness==all-ones OR pwm_cnt<brightness. brightness=0 means the display is always dark.
- Output stage: an, seg and dp are registered, giving 1 cycle latency from scan_idx/storage to pins.
  - an has the bit for scan_idx active when enabled and not ghost-blanked; all other bits are inactive.
  - seg/dp show the decoded entry[scan_idx]. If that entry has blank=1, seg and dp are inactive regardless of an.
- Decode (active-high form, {g..a}): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71. ACTIVE_LOW inverts seg, dp and an.
- Write-to-pin latency: a write at edge N to the currently scanned digit appears on seg at edge N+1. Otherwise it appears at the first output update of that digit's slot.
- Reset mid-scan: immediate return to the reset state. Scanning restarts at digit 0 with prescaler 0.
- Inputs changing mid-slot: brightness changes take effect on the next cycle. No other input alters the scan timing.

Test Plan:
1. Sim params NUM_DIGITS=4, REFRESH_DIV=4, PWM_BITS=2, HEX_MODE=0, ACTIVE_LOW=1. Release reset with no writes -> an=4'hF and seg=7'h7F throughout; scan_idx cycles 0,1,2,3,0 every 4 clocks.
2. Write pos=2 data=7 dp=1 blank=0, brightness=3 -> wr_ack pulses 1 cycle. During the slot where scan_idx==2, after the ghost cycle: an=4'b1011, seg=~7'h07=7'h78, dp=0.
3. Write data=12 (HEX_MODE=0) -> wr_err pulses, entry unchanged. Write pos=3 data=9 -> ack. With HEX_MODE=1, data=12 -> ack and seg=~7'h39.
4. brightness=1 with digit 0 holding 5 -> an[0] active only on cycles where pwm_cnt==0 within slot 0. brightness=0 -> an stays 4'hF.
5. clear and wr_en asserted together -> neither ack nor err. All digits dark, and prior values reappear after blank=0 rewrites with identical data.
6. Assert reset mid-slot 2 -> outputs go inactive immediately. After release, scan_idx=0, all digits blank, first enable occurs at prescaler=1.

Source files
------------

// File: rtl/display_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : display_scan_ctrl
//  Purpose  : Multiplexed 7-segment scan controller. Holds a per-digit
//             register file (value, decimal point, blank) behind a checked
//             write port and time-multiplexes one segment bus across the
//             digit enables with a refresh prescaler, a one-cycle ghosting
//             blank at the start of every slot and PWM brightness.
//  Revision : 1.0  initial release
// ============================================================================
module display_scan_ctrl #(
  parameter  int NUM_DIGITS  = 8,
  parameter  int REFRESH_DIV = 50000,
  parameter  int HEX_MODE    = 0,
  parameter  int PWM_BITS    = 4,
  parameter  int ACTIVE_LOW  = 1,
  localparam int POS_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  wr_en_i,
  input  logic [POS_W-1:0]      wr_pos_i,
  input  logic [3:0]            wr_data_i,
  input  logic                  wr_dp_i,
  input  logic                  wr_blank_i,
  input  logic                  clear_i,
  input  logic [PWM_BITS-1:0]   brightness_i,
  output logic                  wr_ack_o,
  output logic                  wr_err_o,
  output logic [NUM_DIGITS-1:0] an_o,
  output logic [6:0]            seg_o,
  output logic                  dp_o,
  output logic [POS_W-1:0]      scan_idx_o
);

  localparam int                PRE_W    = $clog2(REFRESH_DIV);
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(REFRESH_DIV - 1);
  localparam logic [POS_W-1:0]  POS_LAST = POS_W'(NUM_DIGITS - 1);
  localparam logic              INV      = (ACTIVE_LOW != 0);
  localparam logic [PWM_BITS-1:0] BR_FULL = '1;

  // Active-high segment pattern {g,f,e,d,c,b,a} for a nibble.
  function automatic logic [6:0] dec7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
      4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
      4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
      4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Write qualification; a same-cycle clear suppresses both outcomes.
  logic w_pos_ok, w_data_ok, w_accept, w_reject;
  assign w_pos_ok  = ({1'b0, wr_pos_i} < (POS_W + 1)'(NUM_DIGITS));
  assign w_data_ok = (HEX_MODE != 0) || (wr_data_i < 4'd10);
  assign w_accept  = wr_en_i && !clear_i && w_pos_ok && w_data_ok;
  assign w_reject  = wr_en_i && !clear_i && !(w_pos_ok && w_data_ok);

  logic [3:0]            w_val [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] w_dp;
  logic [NUM_DIGITS-1:0] w_blank;

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_entry
      logic [3:0] val_q;
      logic       dp_q;
      logic       blank_q;

      // Digit entry: clear darkens it but keeps value/dp; accepted write loads it.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          val_q   <= 4'd0;
          dp_q    <= 1'b0;
          blank_q <= 1'b1;
        end else if (clear_i) begin
          blank_q <= 1'b1;
        end else if (w_accept && (wr_pos_i == POS_W'(gi))) begin
          val_q   <= wr_data_i;
          dp_q    <= wr_dp_i;
          blank_q <= wr_blank_i;
        end
      end

      assign w_val[gi]   = val_q;
      assign w_dp[gi]    = dp_q;
      assign w_blank[gi] = blank_q;
    end
  endgenerate

  logic [PRE_W-1:0]    presc_q;
  logic [POS_W-1:0]    scan_q;
  logic [PWM_BITS-1:0] pwm_q;
  logic                ack_q, err_q;

  // Slot prescaler and digit scan pointer; pointer steps on prescaler wrap.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_q <= '0;
      scan_q  <= '0;
    end else if (presc_q == PRE_LAST) begin
      presc_q <= '0;
      scan_q  <= (scan_q == POS_LAST) ? '0 : scan_q + 1'b1;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

  // Free-running PWM phase counter and the one-cycle write response pulses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pwm_q <= '0;
      ack_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      pwm_q <= pwm_q + 1'b1;
      ack_q <= w_accept;
      err_q <= w_reject;
    end
  end

  logic [NUM_DIGITS-1:0] an_d, an_q;
  logic [6:0]            seg_d, seg_q;
  logic                  dp_d, dp_q;
  logic                  w_enable;

  // Next pin state: one enable for the scanned digit unless ghost-blanked or
  // PWM-off; a blanked entry darkens its segments whatever the enable says.
  always_comb begin
    w_enable = (brightness_i == BR_FULL) || (pwm_q < brightness_i);
    an_d     = '0;
    if ((presc_q != '0) && w_enable) begin
      an_d[scan_q] = 1'b1;
    end
    seg_d = w_blank[scan_q] ? 7'd0 : dec7(w_val[scan_q]);
    dp_d  = !w_blank[scan_q] && w_dp[scan_q];
    an_d  = an_d ^ {NUM_DIGITS{INV}};
    seg_d = seg_d ^ {7{INV}};
    dp_d  = dp_d ^ INV;
  end

  // Registered pin stage; reset drives every pin to its inactive level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      an_q  <= {NUM_DIGITS{INV}};
      seg_q <= {7{INV}};
      dp_q  <= INV;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign wr_ack_o   = ack_q;
  assign wr_err_o   = err_q;
  assign an_o       = an_q;
  assign seg_o      = seg_q;
  assign dp_o       = dp_q;
  assign scan_idx_o = scan_q;

endmodule
`default_nettype wire

// File: tb/tb_display_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_display_scan_ctrl
//  Purpose  : Self-checking bench for display_scan_ctrl (4 digits, slot of
//             4 clocks, 2-bit PWM, active-low pins). A decimal-only and a
//             hex-capable instance share the same stimulus.
//  Revision : 1.0  initial release
// ============================================================================
module tb_display_scan_ctrl;

  localparam int N = 4;
  localparam int R = 4;
  localparam int P = 4;    // PWM period = 2**PWM_BITS

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [1:0] wr_pos = '0;
  logic [3:0] wr_data = '0;
  logic       wr_dp = 1'b0;
  logic       wr_blank = 1'b0;
  logic       clear = 1'b0;
  logic [1:0] bright = '0;

  logic       d_ack, d_err, d_dp, h_ack, h_err, h_dp;
  logic [3:0] d_an, h_an;
  logic [6:0] d_seg, h_seg;
  logic [1:0] d_scan, h_scan;

  display_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(R), .HEX_MODE(0),
                      .PWM_BITS(2), .ACTIVE_LOW(1)) u_dec (
    .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en), .wr_pos_i(wr_pos),
    .wr_data_i(wr_data), .wr_dp_i(wr_dp), .wr_blank_i(wr_blank),
    .clear_i(clear), .brightness_i(bright), .wr_ack_o(d_ack),
    .wr_err_o(d_err), .an_o(d_an), .seg_o(d_seg), .dp_o(d_dp),
    .scan_idx_o(d_scan));

  display_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(R), .HEX_MODE(1),
                      .PWM_BITS(2), .ACTIVE_LOW(1)) u_hex (
    .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en), .wr_pos_i(wr_pos),
    .wr_data_i(wr_data), .wr_dp_i(wr_dp), .wr_blank_i(wr_blank),
    .clear_i(clear), .brightness_i(bright), .wr_ack_o(h_ack),
    .wr_err_o(h_err), .an_o(h_an), .seg_o(h_seg), .dp_o(h_dp),
    .scan_idx_o(h_scan));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: per-instance digit table plus a count of clocks since
  // reset release, from which slot, digit and PWM phase follow arithmetically.
  logic [6:0] c_dec [16];
  int         m_cnt;
  int         m_val   [2][N];
  bit         m_dp    [2][N];
  bit         m_blank [2][N];
  logic [3:0] e_an  [2];
  logic [6:0] e_seg [2];
  logic       e_dp  [2];
  logic       e_ack [2];
  logic       e_err [2];
  logic [1:0] e_scan;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0;
    e_scan = '0;
    for (int k = 0; k < 2; k++) begin
      for (int d = 0; d < N; d++) begin
        m_val[k][d] = 0; m_dp[k][d] = 1'b0; m_blank[k][d] = 1'b1;
      end
      e_an[k] = 4'hF; e_seg[k] = 7'h7F; e_dp[k] = 1'b1;
      e_ack[k] = 1'b0; e_err[k] = 1'b0;
    end
  endtask

  // One clock edge of the reference: pins reflect the pre-edge state.
  task automatic model_edge();
    int  digit, phase, pwm;
    bit  lit, acc;
    if (!rst_n) return;
    digit = (m_cnt / R) % N;
    phase = m_cnt % R;
    pwm   = m_cnt % P;
    lit   = (phase != 0) && ((bright == 2'd3) || (pwm < int'(bright)));
    for (int k = 0; k < 2; k++) begin
      e_an[k]  = lit ? (4'hF ^ (4'd1 << digit)) : 4'hF;
      e_seg[k] = m_blank[k][digit] ? 7'h7F : ~c_dec[m_val[k][digit]];
      e_dp[k]  = m_blank[k][digit] ? 1'b1 : ~m_dp[k][digit];
      acc      = wr_en && !clear && (int'(wr_pos) < N) && ((k == 1) || (wr_data < 4'd10));
      e_ack[k] = acc;
      e_err[k] = wr_en && !clear && !acc;
      if (clear) begin
        for (int d = 0; d < N; d++) m_blank[k][d] = 1'b1;
      end else if (acc) begin
        m_val[k][wr_pos]   = int'(wr_data);
        m_dp[k][wr_pos]    = wr_dp;
        m_blank[k][wr_pos] = wr_blank;
      end
    end
    m_cnt++;
    e_scan = 2'((m_cnt / R) % N);
  endtask

  task automatic compare_all();
    chk("dec_an",   d_an,   e_an[0]);   chk("hex_an",   h_an,   e_an[1]);
    chk("dec_seg",  d_seg,  e_seg[0]);  chk("hex_seg",  h_seg,  e_seg[1]);
    chk("dec_dp",   d_dp,   e_dp[0]);   chk("hex_dp",   h_dp,   e_dp[1]);
    chk("dec_ack",  d_ack,  e_ack[0]);  chk("hex_ack",  h_ack,  e_ack[1]);
    chk("dec_err",  d_err,  e_err[0]);  chk("hex_err",  h_err,  e_err[1]);
    chk("dec_scan", d_scan, e_scan);    chk("hex_scan", h_scan, e_scan);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; clear = 1'b0;
  endtask

  task automatic write(input logic [1:0] p, input logic [3:0] d, input logic dpv, input logic bl);
    wr_en = 1'b1; wr_pos = p; wr_data = d; wr_dp = dpv; wr_blank = bl; clear = 1'b0;
    step();
    idle_inputs();
  endtask

  // Advance until the clock count since release hits the given frame phase.
  task automatic wait_frame(input int target, input string name);
    bit hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      if ((m_cnt % (N * R)) == target) hit = 1'b1;
      else step();
    end
    chk({name, "_reached"}, 32'(hit), 32'd1);
  endtask

  // Asynchronous reset pulse between edges, released away from the edge.
  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_an", d_an, 4'hF);
    chk("rst_seg", d_seg, 7'h7F);
    chk("rst_dp", d_dp, 1'b1);
    chk("rst_scan", d_scan, 2'd0);
    step();
    #2;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic       en;
    logic [1:0] pos;
    logic [3:0] data;
    logic       dpv;
    logic       bl;
    logic       clr;
    logic       ack_d, err_d, ack_h, err_h;
  } vec_t;

  vec_t vecs [7];

  initial begin
    c_dec = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    //          en   pos   data   dp    blk   clr   ackD  errD  ackH  errH
    vecs[0] = '{1'b1, 2'd2, 4'd7,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 2'd1, 4'd12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 2'd3, 4'd9,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 2'd0, 4'd15, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 2'd0, 4'd5,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 2'd1, 4'd3,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 2'd0, 4'd5,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    model_reset();
    #12;
    compare_all();
    rst_n = 1'b1;

    // Idle display after reset: dark pins, scan pointer walking.
    for (int i = 0; i < 2 * N * R; i++) begin
      step();
      chk("t1_an", d_an, 4'hF);
      chk("t1_seg", d_seg, 7'h7F);
    end

    // Write acceptance/rejection table.
    bright = 2'd3;
    for (int i = 0; i < 7; i++) begin
      wr_en = vecs[i].en; wr_pos = vecs[i].pos; wr_data = vecs[i].data;
      wr_dp = vecs[i].dpv; wr_blank = vecs[i].bl; clear = vecs[i].clr;
      step();
      chk("tbl_ack_dec", d_ack, vecs[i].ack_d);
      chk("tbl_err_dec", d_err, vecs[i].err_d);
      chk("tbl_ack_hex", h_ack, vecs[i].ack_h);
      chk("tbl_err_hex", h_err, vecs[i].err_h);
      idle_inputs();
      step();
    end

    // Only digit 0 survives the clear; digit 3 stays dark.
    wait_frame(14, "t5_dark");
    chk("t5_seg3_dark", d_seg, 7'h7F);

    // Rewrite digit 2 with identical data and digit 1 with a hex value.
    write(2'd2, 4'd7, 1'b1, 1'b0);
    write(2'd1, 4'd12, 1'b0, 1'b0);
    wait_frame(6, "t3_hex");
    chk("t3_hex_seg", h_seg, 7'h46);
    chk("t3_dec_seg", d_seg, 7'h7F);
    wait_frame(10, "t2_slot2");
    chk("t2_an", d_an, 4'b1011);
    chk("t2_seg", d_seg, 7'h78);
    chk("t2_dp", d_dp, 1'b0);

    // Brightness sweep; with slot length equal to the PWM period the only
    // pwm_cnt==0 cycle is the ghost cycle, so brightness 1 stays dark.
    bright = 2'd1;
    for (int i = 0; i < N * R; i++) begin step(); chk("t4_b1_an", d_an, 4'hF); end
    bright = 2'd2;
    wait_frame(2, "t4_b2");
    chk("t4_b2_an", d_an, 4'b1110);
    chk("t4_b2_seg", d_seg, 7'h12);
    bright = 2'd0;
    for (int i = 0; i < N * R; i++) begin step(); chk("t4_b0_an", d_an, 4'hF); end

    // Reset in the middle of slot 2.
    bright = 2'd3;
    wait_frame(9, "t6_mid");
    pulse_reset();
    step();
    chk("t6_ghost_an", d_an, 4'hF);
    step();
    chk("t6_first_an", d_an, 4'b1110);
    chk("t6_first_seg", d_seg, 7'h7F);

    // Randomised traffic against the model.
    for (int i = 0; i < 500; i++) begin
      wr_en    = ($urandom_range(0, 2) == 0);
      wr_pos   = 2'($urandom_range(0, 3));
      wr_data  = 4'($urandom_range(0, 15));
      wr_dp    = 1'($urandom_range(0, 1));
      wr_blank = ($urandom_range(0, 5) == 0);
      clear    = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 15) == 0) bright = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 150) == 0) begin
        idle_inputs();
        pulse_reset();
      end else begin
        step();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
